// File: rtl/pkt_serializer_if.sv
// Packet type shared by the FIFO, the serializer and its environment, plus the
// bundle of FIFO-read and byte-egress signals used as the serializer's port.
// master: the serializer side (pops the FIFO, drives the byte stream).
// slave : the FIFO / downstream side.

package pkt_serializer_pkg;

    // One FIFO entry: routing header followed by four payload bytes.
    // data[0] is transmitted first.
    typedef struct packed {
        logic [7:0]      src;
        logic [7:0]      dst;
        logic [0:3][7:0] data;
    } packet_t;

endpackage

interface pkt_serializer_if;
    import pkt_serializer_pkg::*;

    // FIFO read port
    packet_t    fifo_dout;
    logic       fifo_emptyp;
    logic       fifo_readp;

    // Byte-wide egress link
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_sop;
    logic       tx_eop;

    modport master (
        input  fifo_dout,
        input  fifo_emptyp,
        output fifo_readp,
        output tx_data,
        output tx_valid,
        input  tx_ready,
        output tx_sop,
        output tx_eop
    );

    modport slave (
        output fifo_dout,
        output fifo_emptyp,
        input  fifo_readp,
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        input  tx_sop,
        input  tx_eop
    );

endinterface

// File: rtl/pkt_serializer.sv
// pkt_serializer: pops one packet_t at a time from the packet FIFO and sends
// it as a byte stream (src, dst, data[0..3]) over a valid/ready link, with
// start/end-of-packet markers, an optional idle gap after each packet and a
// wrapping count of fully transmitted packets.
//
// Build option: define PKT_SER_CSUM_EN to append a 7th beat carrying the XOR
// of all six packet bytes; tx_eop then moves to that beat.
//
// Only fifo_readp is decoded from the state; every other output is a register
// so the link sees clean, glitch-free signals.

module pkt_serializer
    import pkt_serializer_pkg::*;
#(
    // Idle cycles inserted after the last accepted beat (0..15)
    parameter int unsigned IDLE_GAP = 0
) (
    input  logic             clk,
    input  logic             rstn,
    pkt_serializer_if.master bus,
    output logic             busy,
    output logic [15:0]      pkt_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

`ifdef PKT_SER_CSUM_EN
    localparam int NUM_BEATS = 7;
`else
    localparam int NUM_BEATS = 6;
`endif
    localparam logic [2:0] LAST_BEAT = 3'(NUM_BEATS - 1);
    // The GAP state runs while the counter walks down to zero, so it is loaded
    // with one less than the requested gap length.
    localparam logic [3:0] GAP_LOAD  = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

    state_t      r_state;
    logic [2:0]  r_beat;
    packet_t     r_shadow;
    logic [3:0]  r_gap_cnt;
    logic [15:0] r_pkt_cnt;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic        r_tx_sop;
    logic        r_tx_eop;
    logic        r_busy;

    logic [7:0]  w_beat_byte [NUM_BEATS];
    logic [2:0]  w_next_beat;
    logic [7:0]  w_next_byte;
    logic        w_accept;

    // Byte table of the captured packet, indexed by beat number.
    assign w_beat_byte[0] = r_shadow.src;
    assign w_beat_byte[1] = r_shadow.dst;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_payload
            assign w_beat_byte[gi + 2] = r_shadow.data[gi];
        end
    endgenerate

`ifdef PKT_SER_CSUM_EN
    // Trailer beat: XOR of every byte of the captured packet.
    assign w_beat_byte[6] = r_shadow.src     ^ r_shadow.dst     ^
                            r_shadow.data[0] ^ r_shadow.data[1] ^
                            r_shadow.data[2] ^ r_shadow.data[3];
`endif

    assign w_next_beat = r_beat + 3'd1;
    assign w_accept    = r_tx_valid && bus.tx_ready;

    // Select the byte for the beat that follows the one currently on the link.
    always_comb begin
        w_next_byte = 8'h00;
        for (int i = 0; i < NUM_BEATS; i++) begin
            if (w_next_beat == 3'(i)) begin
                w_next_byte = w_beat_byte[i];
            end
        end
    end

    // Main sequencer: IDLE -> FETCH -> SEND (beat by beat) -> [GAP] -> IDLE,
    // updating every registered output alongside the state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_beat     <= 3'd0;
            r_shadow   <= '0;
            r_gap_cnt  <= 4'd0;
            r_pkt_cnt  <= 16'd0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_tx_sop   <= 1'b0;
            r_tx_eop   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!bus.fifo_emptyp) begin
                        r_state <= S_FETCH;
                        r_busy  <= 1'b1;
                    end
                end

                // The FIFO presents its head entry during this cycle; the pop
                // and the capture happen on the same edge, and beat 0 goes
                // straight onto the link.
                S_FETCH: begin
                    r_shadow   <= bus.fifo_dout;
                    r_beat     <= 3'd0;
                    r_tx_data  <= bus.fifo_dout.src;
                    r_tx_valid <= 1'b1;
                    r_tx_sop   <= 1'b1;
                    r_tx_eop   <= 1'b0;
                    r_state    <= S_SEND;
                end

                // Outputs only move on an accepted beat, so backpressure holds
                // data and markers stable.
                S_SEND: begin
                    if (w_accept) begin
                        if (r_beat == LAST_BEAT) begin
                            r_pkt_cnt  <= r_pkt_cnt + 16'd1;
                            r_beat     <= 3'd0;
                            r_tx_data  <= 8'h00;
                            r_tx_valid <= 1'b0;
                            r_tx_sop   <= 1'b0;
                            r_tx_eop   <= 1'b0;
                            if (IDLE_GAP > 0) begin
                                r_state   <= S_GAP;
                                r_gap_cnt <= GAP_LOAD;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_beat    <= w_next_beat;
                            r_tx_data <= w_next_byte;
                            r_tx_sop  <= 1'b0;
                            r_tx_eop  <= (w_next_beat == LAST_BEAT);
                        end
                    end
                end

                S_GAP: begin
                    if (r_gap_cnt == 4'd0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Pop strobe is a pure state decode so the FIFO sees it in the FETCH cycle.
    assign bus.fifo_readp = (r_state == S_FETCH);

    assign bus.tx_data  = r_tx_data;
    assign bus.tx_valid = r_tx_valid;
    assign bus.tx_sop   = r_tx_sop;
    assign bus.tx_eop   = r_tx_eop;
    assign busy         = r_busy;
    assign pkt_cnt      = r_pkt_cnt;

endmodule

// File: tb/tb_pkt_serializer.sv
// Testbench for pkt_serializer. Two instances (IDLE_GAP = 0 and 3) share the
// same packet stream and tx_ready. Each has its own FIFO model; a single
// monitor compares every cycle against a cycle-level reference built from the
// packet rules: the FIFO is looked at no earlier than 1+IDLE_GAP cycles after
// an end-of-packet acceptance, the first beat appears 2 cycles after a
// non-empty look, and bytes/markers follow from the queued packet.

module tb_pkt_serializer;
    import pkt_serializer_pkg::*;

`ifdef PKT_SER_CSUM_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif
    localparam int NDUT = 2;
    localparam int GAP0 = 0;
    localparam int GAP1 = 3;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic tx_ready = 1'b1;
    logic timeout_flag = 1'b0;

    always #5 clk = ~clk;

    packet_t     dout_a   [NDUT];
    logic        emptyp_a [NDUT];
    logic        readp_a  [NDUT];
    logic        valid_a  [NDUT];
    logic        sop_a    [NDUT];
    logic        eop_a    [NDUT];
    logic        busy_a   [NDUT];
    logic [7:0]  data_a   [NDUT];
    logic [15:0] cnt_a    [NDUT];

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            pkt_serializer_if bus();
            assign bus.fifo_dout   = dout_a[gi];
            assign bus.fifo_emptyp = emptyp_a[gi];
            assign bus.tx_ready    = tx_ready;
            assign readp_a[gi]     = bus.fifo_readp;
            assign valid_a[gi]     = bus.tx_valid;
            assign sop_a[gi]       = bus.tx_sop;
            assign eop_a[gi]       = bus.tx_eop;
            assign data_a[gi]      = bus.tx_data;

            pkt_serializer #(.IDLE_GAP((gi == 0) ? GAP0 : GAP1)) u_dut (
                .clk     (clk),
                .rstn    (rstn),
                .bus     (bus),
                .busy    (busy_a[gi]),
                .pkt_cnt (cnt_a[gi])
            );
        end
    endgenerate

    // ---------------- reference helpers ----------------
    function automatic int gap_of(input int k);
        return (k == 0) ? GAP0 : GAP1;
    endfunction

    function automatic logic [7:0] pkt_byte(input packet_t p, input int i);
        logic [7:0] b [7];
        b[0] = p.src;
        b[1] = p.dst;
        for (int j = 0; j < 4; j++) b[2 + j] = p.data[j];
        b[6] = p.src ^ p.dst ^ p.data[0] ^ p.data[1] ^ p.data[2] ^ p.data[3];
        return b[i];
    endfunction

    // ---------------- scoreboard state ----------------
    packet_t     exp_q  [NDUT][$];
    packet_t     fifo_q [NDUT][$];
    packet_t     src_q  [NDUT][$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          idx     [NDUT] = '{0, 0};
    int          exp_sop [NDUT] = '{-1, -1};
    int          look    [NDUT] = '{0, 0};
    int          pkts    [NDUT] = '{0, 0};
    logic [15:0] mcnt    [NDUT] = '{16'd0, 16'd0};
    bit          m_vexp;
    bit          m_bexp;
    bit          timeout_seen = 1'b0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h expected=%0h", name, k, cyc, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < NDUT; k++) begin
            if (!rstn) begin
                chk("reset_outputs", k,
                    32'({readp_a[k], valid_a[k], sop_a[k], eop_a[k], busy_a[k], data_a[k], cnt_a[k]}), 32'd0);
                if (exp_sop[k] >= 0 && cyc >= exp_sop[k] && exp_q[k].size() > 0)
                    void'(exp_q[k].pop_front());
                idx[k]     = 0;
                exp_sop[k] = -1;
                look[k]    = 0;
                mcnt[k]    = 16'd0;
            end else begin
                if (exp_sop[k] < 0 && cyc >= look[k] && !emptyp_a[k])
                    exp_sop[k] = cyc + 2;
                m_vexp = (exp_sop[k] >= 0) && (cyc >= exp_sop[k]);
                m_bexp = (cyc < look[k]) || ((exp_sop[k] >= 0) && (cyc >= exp_sop[k] - 1));
                chk("pkt_cnt",  k, 32'(cnt_a[k]),   32'(mcnt[k]));
                chk("readp",    k, 32'(readp_a[k]), 32'(exp_sop[k] == cyc + 1));
                chk("busy",     k, 32'(busy_a[k]),  32'(m_bexp));
                chk("tx_valid", k, 32'(valid_a[k]), 32'(m_vexp));
                if (m_vexp && valid_a[k]) begin
                    if (exp_q[k].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL beat_without_packet dut%0d cyc=%0d got=%02h expected=none", k, cyc, data_a[k]);
                    end else begin
                        chk("tx_data", k, 32'(data_a[k]), 32'(pkt_byte(exp_q[k][0], idx[k])));
                        chk("tx_sop",  k, 32'(sop_a[k]),  32'(idx[k] == 0));
                        chk("tx_eop",  k, 32'(eop_a[k]),  32'(idx[k] == NB - 1));
                        if (tx_ready) begin
                            idx[k]++;
                            if (idx[k] == NB) begin
                                pkts[k]++;
                                $display("[TB] dut%0d pkt %0d src=%02h dst=%02h sent at cyc %0d",
                                         k, pkts[k], exp_q[k][0].src, exp_q[k][0].dst, cyc);
                                void'(exp_q[k].pop_front());
                                idx[k]     = 0;
                                mcnt[k]    = mcnt[k] + 16'd1;
                                look[k]    = cyc + 1 + gap_of(k);
                                exp_sop[k] = -1;
                            end
                        end
                    end
                end
            end
        end
        if (timeout_flag && !timeout_seen) begin
            timeout_seen = 1'b1;
            n_tests++;
            n_fail++;
            $display("FAIL wait_bound expired at cyc=%0d", cyc);
        end
    end

    // ---------------- stimulus ----------------
    // One clock of the environment: FIFO pops on a pop strobe seen in the
    // previous cycle, writes are accepted while there is room.
    task automatic tick();
        logic rd [NDUT];
        for (int k = 0; k < NDUT; k++) rd[k] = readp_a[k];
        @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            if (rd[k] && fifo_q[k].size() > 0) void'(fifo_q[k].pop_front());
            while (src_q[k].size() > 0 && fifo_q[k].size() < 4)
                fifo_q[k].push_back(src_q[k].pop_front());
            emptyp_a[k] = (fifo_q[k].size() == 0);
            dout_a[k]   = (fifo_q[k].size() > 0) ? fifo_q[k][0] : '0;
        end
    endtask

    task automatic send_pkt(input packet_t p);
        for (int k = 0; k < NDUT; k++) begin
            src_q[k].push_back(p);
            exp_q[k].push_back(p);
        end
    endtask

    function automatic bit all_idle();
        for (int k = 0; k < NDUT; k++)
            if (exp_q[k].size() != 0 || src_q[k].size() != 0 || fifo_q[k].size() != 0 || busy_a[k])
                return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input int budget);
        int t = 0;
        do begin
            tick();
            t++;
        end while (!all_idle() && t < budget);
        if (!all_idle()) timeout_flag = 1'b1;
    endtask

    task automatic wait_beat(input logic [7:0] b, input int budget);
        int t = 0;
        while (!(valid_a[0] && data_a[0] == b) && t < budget) begin
            tick();
            t++;
        end
        if (!(valid_a[0] && data_a[0] == b)) timeout_flag = 1'b1;
    endtask

    function automatic packet_t rand_pkt();
        packet_t p;
        p.src = 8'($urandom);
        p.dst = 8'($urandom);
        for (int j = 0; j < 4; j++) p.data[j] = 8'($urandom);
        return p;
    endfunction

    initial begin
        packet_t pd;
        int      pushed;
        int      t;

        for (int k = 0; k < NDUT; k++) begin
            emptyp_a[k] = 1'b1;
            dout_a[k]   = '0;
        end
        pd.src = 8'h11;
        pd.dst = 8'h22;
        for (int j = 0; j < 4; j++) pd.data[j] = 8'hA0 + 8'(j);

        // Reset
        rstn = 1'b0;
        tx_ready = 1'b1;
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        // Single directed packet, link always ready
        send_pkt(pd);
        wait_idle(100);

        // Backpressure: ready low for 3 cycles while beat 2 (0xA0) is shown
        send_pkt(pd);
        wait_beat(8'hA0, 50);
        tx_ready = 1'b0;
        repeat (3) tick();
        tx_ready = 1'b1;
        wait_idle(100);

        // Full FIFO, back-to-back
        for (int i = 0; i < 4; i++) send_pkt(rand_pkt());
        wait_idle(200);

        // Random traffic and random backpressure
        pushed = 0;
        t = 0;
        while (pushed < 40 && t < 3000) begin
            if ($urandom_range(0, 2) == 0 && src_q[0].size() < 2) begin
                send_pkt(rand_pkt());
                pushed++;
            end
            tx_ready = ($urandom_range(0, 3) != 0);
            tick();
            t++;
        end
        if (pushed < 40) timeout_flag = 1'b1;
        tx_ready = 1'b1;
        wait_idle(1000);

        // Reset while beat 3 (0xA1) is on the link; next packet from beat 0
        send_pkt(pd);
        send_pkt(rand_pkt());
        wait_beat(8'hA1, 50);
        rstn = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        wait_idle(200);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pkt_serializer.md
# pkt_serializer

Drain side of the 4-entry packet FIFO: pops one `packet_t` at a time (src, dst, data[0:3]) and transmits it as a byte stream over a valid/ready link. Sits between the FIFO read port and the byte-wide egress interface. It provides:

- Start-of-packet and end-of-packet markers.
- A configurable inter-packet gap.
- A running packet counter.
- An optional XOR checksum trailer beat.

## Interface

Parameters:

- `IDLE_GAP`, default 0. Minimum idle cycles inserted after the last accepted beat of a packet, before the next FIFO check. Range 0..15.

Ports:

- `clk` input 1: the only clock. All state changes on its rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `fifo_dout` input `packet_t`: registered FIFO read data.
- `fifo_emptyp` input 1: FIFO empty flag, active high.
- `fifo_readp` output 1: pop request to the FIFO, active high, one cycle per packet.
- `tx_data` output 8: current byte.
- `tx_valid` output 1: byte valid.
- `tx_ready` input 1: downstream accepts the byte when high together with `tx_valid`.
- `tx_sop` output 1: first beat of a packet (`src`).
- `tx_eop` output 1: last beat of a packet.
- `busy` output 1: high in every state except IDLE.
- `pkt_cnt` output 16: packets fully transmitted. Wraps 0xFFFF -> 0x0000.

## Operation

States:

- **IDLE**
  - `fifo_emptyp` low -> FETCH.
  - Otherwise stay in IDLE.
- **FETCH** (exactly 1 cycle)
  - `fifo_readp` = 1, decoded from the state, not registered.
  - On the exiting edge: `fifo_dout` is captured into a shadow packet register, `beat` <= 0, and state -> SEND.
- **SEND**
  - `tx_valid` = 1, `tx_data` = shadow byte selected by `beat`.
  - Beat order: 0 = `src`, 1 = `dst`, 2..5 = `data[0]`..`data[3]`.
  - `tx_sop` = 1 only on beat 0. `tx_eop` = 1 only on the last beat (beat 5, or beat 6 with the checksum).
  - On `tx_valid && tx_ready`: advance `beat`. After the last beat, increment `pkt_cnt` and go to GAP if `IDLE_GAP` > 0, else IDLE.
  - While `tx_ready` is low, `tx_data`, `tx_sop`, `tx_eop` and `tx_valid` hold unchanged.
- **GAP**
  - Counts `IDLE_GAP` cycles, then -> IDLE.

Rules:

- Only one packet is in flight. The shadow register is never overwritten during SEND/GAP.
- `fifo_readp` is never asserted while `fifo_emptyp` is high. FETCH is entered only from IDLE with the FIFO non-empty.
- `beat` is a 3-bit counter.
- `pkt_cnt` is 16-bit unsigned with natural wrap.

Reset (`rstn` low, at any time, including mid-packet):

- State -> IDLE, and `beat`, `pkt_cnt`, the gap counter and the shadow register clear to 0.
- All outputs go to 0 immediately, not waiting for a clock edge.
- A partially sent packet is dropped. There is no resume after reset.

## Timing

- FIFO write at edge E0 -> `fifo_emptyp` low after E0.
- E1: FETCH. `fifo_dout` is valid, because the FIFO registered `fifomem[tail]` at E1.
- E2: pop and capture. `tx_valid` goes high with `src` and `tx_sop` = 1.
- Latency from `fifo_emptyp` falling to the first `tx_valid` = 2 cycles.
- With `tx_ready` held high:
  - 6 beats (7 with checksum) in consecutive cycles.
  - Packet period = beats + 2 + `IDLE_GAP` cycles.
- `fifo_emptyp` reflects the pop by the first SEND cycle. `fifo_dout` shows the next entry before the following FETCH.
- All outputs except `fifo_readp` are registered.

## Configuration

Macro `PKT_SER_CSUM_EN`:

- **Defined:** a 7th beat (beat 6) is appended.
  - Its value is `src ^ dst ^ data[0] ^ data[1] ^ data[2] ^ data[3]`, computed from the shadow register.
  - `tx_eop` is on beat 6; beat 5 has `tx_eop` = 0.
- **Undefined:** 6 beats, `tx_eop` on beat 5, and no checksum logic.

## Test plan

1. **Reset:** `rstn` low -> all outputs 0, `pkt_cnt` = 0.
2. **Single packet:** FIFO holds src=0x11, dst=0x22, data=0xA0..0xA3; `tx_ready`=1.
   - One `fifo_readp` pulse.
   - Bytes 11,22,A0,A1,A2,A3 on 6 consecutive cycles, first beat 2 cycles after `fifo_emptyp` falls.
   - `tx_sop` on 0x11, `tx_eop` on 0xA3, `pkt_cnt`=1.
   - With `PKT_SER_CSUM_EN`: 7th byte 0x33, `tx_eop` moves to it.
3. **Backpressure:** `tx_ready` low for 3 cycles on beat 2 -> `tx_data`=0xA0 and `tx_valid`=1 held for 3 cycles, then the sequence resumes. No byte is lost or duplicated.
4. **Full FIFO, back-to-back:** 4 packets, `IDLE_GAP`=0, `tx_ready`=1.
   - 4 `fifo_readp` pulses, 8-cycle period, packets in FIFO order.
   - `pkt_cnt`=4; `busy` low once the FIFO is empty.
5. **Gap:** `IDLE_GAP`=3 -> exactly 3 GAP cycles, plus IDLE and FETCH, between `tx_eop` acceptance and the next `tx_sop`.
6. **Reset mid-packet:** `rstn` low during beat 3 -> outputs 0 asynchronously. After release, the next FIFO packet is sent from beat 0, and `pkt_cnt` restarts at 0.
